// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: address width, reset PC, NOP encoding and
// the IF/ID bundle consumed by the ID stage.
package mips_pkg;

  localparam int unsigned AW       = 5;
  localparam int unsigned RESET_PC = 0;
  localparam int unsigned IW       = 32;

  localparam logic [IW-1:0] NOP_INSTR = 32'h0000_0000;

  // IF/ID boundary payload; valid = 0 marks a bubble
  typedef struct packed {
    logic [IW-1:0] instruction;
    logic [AW-1:0] pcplus1;
    logic          valid;
  } ifid_t;

endpackage

// File: rtl/fetch_next_pc.sv
// Next-PC and IF/ID update select for the fetch stage.
// Ports:
//   pc_i            current PC
//   stall_i         hazard-unit hold request
//   branch_taken_i  resolved taken branch (older instruction, wins over jump)
//   branch_target_i branch target word address
//   jump_i          decoded jump
//   jump_target_i   jump target word address
//   next_pc_o       PC value for the next edge
//   pc_plus1_o      PC+1, wrapping modulo 2^AW
//   flush_o         load a bubble into IF/ID
//   capture_o       load the fetched instruction into IF/ID
module fetch_next_pc #(
  parameter int unsigned AW = mips_pkg::AW
) (
  input  logic [AW-1:0] pc_i,
  input  logic          stall_i,
  input  logic          branch_taken_i,
  input  logic [AW-1:0] branch_target_i,
  input  logic          jump_i,
  input  logic [AW-1:0] jump_target_i,
  output logic [AW-1:0] next_pc_o,
  output logic [AW-1:0] pc_plus1_o,
  output logic          flush_o,
  output logic          capture_o
);

  assign pc_plus1_o = pc_i + AW'(1);

  // Redirects override a stall; branch beats jump
  always_comb begin
    next_pc_o = pc_i;
    flush_o   = 1'b0;
    capture_o = 1'b0;
    if (branch_taken_i) begin
      next_pc_o = branch_target_i;
      flush_o   = 1'b1;
    end else if (jump_i) begin
      next_pc_o = jump_target_i;
      flush_o   = 1'b1;
    end else if (!stall_i) begin
      next_pc_o = pc_plus1_o;
      capture_o = 1'b1;
    end
  end

endmodule

// File: rtl/instruction_fetch_stage.sv
// IF stage: owns the PC, addresses instruction memory combinationally and
// registers the fetched instruction plus PC+1 into IF/ID.
// Ports:
//   CLK, Reset         clock and synchronous active-high reset
//   Stall              hold PC, IF/ID and FetchCount
//   BranchTaken/Target taken-branch redirect (highest priority)
//   Jump/JumpTarget    jump redirect
//   Address            PC register, to instruction memory
//   Instruction        instruction memory read data for Address
//   IFID_*             IF/ID register outputs
//   FetchCount         instructions accepted into IF/ID, wraps modulo 2^CW
module instruction_fetch_stage #(
  parameter int unsigned   AW       = mips_pkg::AW,
  parameter logic [AW-1:0] RESET_PC = AW'(mips_pkg::RESET_PC),
  parameter int unsigned   CW       = 16
) (
  input  logic          CLK,
  input  logic          Reset,
  input  logic          Stall,
  input  logic          BranchTaken,
  input  logic [AW-1:0] BranchTarget,
  input  logic          Jump,
  input  logic [AW-1:0] JumpTarget,
  output logic [AW-1:0] Address,
  input  logic [31:0]   Instruction,
  output logic [31:0]   IFID_Instruction,
  output logic [AW-1:0] IFID_PCPlus1,
  output logic          IFID_Valid,
  output logic [CW-1:0] FetchCount
);

  import mips_pkg::NOP_INSTR;

  logic [AW-1:0] pc_q, pc_d;
  logic [31:0]   instr_q, instr_d;
  logic [AW-1:0] pcplus1_q, pcplus1_d;
  logic          valid_q, valid_d;
  logic [CW-1:0] count_q, count_d;

  logic [AW-1:0] next_pc;
  logic [AW-1:0] pc_plus1;
  logic          flush;
  logic          capture;

  fetch_next_pc #(.AW(AW)) u_next_pc (
    .pc_i            (pc_q),
    .stall_i         (Stall),
    .branch_taken_i  (BranchTaken),
    .branch_target_i (BranchTarget),
    .jump_i          (Jump),
    .jump_target_i   (JumpTarget),
    .next_pc_o       (next_pc),
    .pc_plus1_o      (pc_plus1),
    .flush_o         (flush),
    .capture_o       (capture)
  );

  // IF/ID and counter next state
  always_comb begin
    pc_d      = next_pc;
    instr_d   = instr_q;
    pcplus1_d = pcplus1_q;
    valid_d   = valid_q;
    count_d   = count_q;
    if (flush) begin
      instr_d   = NOP_INSTR;
      pcplus1_d = '0;
      valid_d   = 1'b0;
    end else if (capture) begin
      instr_d   = Instruction;
      pcplus1_d = pc_plus1;
      valid_d   = 1'b1;
      count_d   = count_q + CW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      pc_q      <= RESET_PC;
      instr_q   <= NOP_INSTR;
      pcplus1_q <= '0;
      valid_q   <= 1'b0;
      count_q   <= '0;
    end else begin
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      pcplus1_q <= pcplus1_d;
      valid_q   <= valid_d;
      count_q   <= count_d;
    end
  end

  assign Address          = pc_q;
  assign IFID_Instruction = instr_q;
  assign IFID_PCPlus1     = pcplus1_q;
  assign IFID_Valid       = valid_q;
  assign FetchCount       = count_q;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Self-checking bench for instruction_fetch_stage: directed program steps
// followed by random redirect/stall traffic against a reference model.
module tb_instruction_fetch_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        br;
  logic [4:0]  bt;
  logic        jmp;
  logic [4:0]  jt;
  logic [4:0]  addr;
  logic [31:0] instr;
  logic [31:0] ifid_instr;
  logic [4:0]  ifid_pp1;
  logic        ifid_valid;
  logic [15:0] fcount;

  logic [31:0] mem [32];

  int checks = 0;
  int errors = 0;

  // Reference state
  int          m_pc;
  logic [31:0] m_instr;
  int          m_pp1;
  logic        m_valid;
  int          m_cnt;

  instruction_fetch_stage dut (
    .CLK              (clk),
    .Reset            (reset),
    .Stall            (stall),
    .BranchTaken      (br),
    .BranchTarget     (bt),
    .Jump             (jmp),
    .JumpTarget       (jt),
    .Address          (addr),
    .Instruction      (instr),
    .IFID_Instruction (ifid_instr),
    .IFID_PCPlus1     (ifid_pp1),
    .IFID_Valid       (ifid_valid),
    .FetchCount       (fcount)
  );

  assign instr = mem[addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".addr"},  32'(addr),       32'(m_pc));
    check({tag, ".instr"}, ifid_instr,      m_instr);
    check({tag, ".pp1"},   32'(ifid_pp1),   32'(m_pp1));
    check({tag, ".valid"}, 32'(ifid_valid), 32'(m_valid));
    check({tag, ".cnt"},   32'(fcount),     32'(m_cnt));
  endtask

  // Apply one cycle of inputs, advance the model by the fetch rules, compare
  task automatic step(input logic r, input logic s, input logic b, input logic [4:0] btv,
                      input logic j, input logic [4:0] jtv, input string tag);
    reset = r; stall = s; br = b; bt = btv; jmp = j; jt = jtv;
    if (r) begin
      m_pc = 0; m_instr = 32'h0; m_pp1 = 0; m_valid = 1'b0; m_cnt = 0;
    end else if (b || j) begin
      m_pc = b ? int'(btv) : int'(jtv);
      m_instr = 32'h0; m_pp1 = 0; m_valid = 1'b0;
    end else if (!s) begin
      m_instr = mem[m_pc];
      m_pp1   = (m_pc + 1) % 32;
      m_pc    = m_pp1;
      m_valid = 1'b1;
      m_cnt   = (m_cnt + 1) % 65536;
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; br = 1'b0; bt = '0; jmp = 1'b0; jt = '0;
    for (int i = 0; i < 32; i++) mem[i] = $urandom;
    mem[0]  = 32'h2410_0000;
    mem[1]  = 32'h2411_0004;
    mem[4]  = 32'h0800_000C;
    mem[6]  = 32'h8E29_0000;
    mem[12] = 32'h1613_FFF9;

    step(1, 0, 0, 0, 0, 0, "reset0");
    step(1, 1, 1, 7, 1, 9, "reset1");
    check("reset_addr", 32'(addr), 32'h0);

    step(0, 0, 0, 0, 0, 0, "fetch0");
    check("first_instr", ifid_instr, 32'h2410_0000);
    check("first_pp1", 32'(ifid_pp1), 32'd1);
    check("first_cnt", 32'(fcount), 32'd1);
    step(0, 0, 0, 0, 0, 0, "fetch1");
    check("second_instr", ifid_instr, 32'h2411_0004);
    step(0, 0, 0, 0, 0, 0, "fetch2");
    step(0, 0, 0, 0, 0, 0, "fetch3");
    check("at_jump_addr", 32'(addr), 32'd4);

    step(0, 0, 0, 0, 1, 12, "jump");
    check("jump_addr", 32'(addr), 32'd12);
    check("jump_bubble", 32'(ifid_valid), 32'd0);
    check("jump_cnt_hold", 32'(fcount), 32'd4);
    step(0, 0, 0, 0, 0, 0, "after_jump");
    check("jt_instr", ifid_instr, 32'h1613_FFF9);
    check("jt_pp1", 32'(ifid_pp1), 32'd13);

    step(0, 0, 1, 6, 0, 0, "br6");
    step(0, 0, 0, 0, 0, 0, "to7");
    step(0, 0, 0, 6, 1, 6, "j6");
    step(0, 1, 0, 0, 0, 0, "stall0");
    step(0, 1, 0, 0, 0, 0, "stall1");
    step(0, 1, 0, 0, 0, 0, "stall2");
    check("stall_addr", 32'(addr), 32'd6);
    step(0, 0, 0, 0, 0, 0, "unstall");
    check("unstall_instr", ifid_instr, 32'h8E29_0000);
    check("unstall_pp1", 32'(ifid_pp1), 32'd7);

    step(0, 1, 1, 5, 1, 12, "br_jmp_stall");
    check("prio_addr", 32'(addr), 32'd5);
    check("prio_bubble", 32'(ifid_valid), 32'd0);

    step(0, 0, 0, 0, 1, 31, "j31");
    step(0, 0, 0, 0, 0, 0, "wrap");
    check("wrap_addr", 32'(addr), 32'd0);
    check("wrap_pp1", 32'(ifid_pp1), 32'd0);
    check("wrap_valid", 32'(ifid_valid), 32'd1);

    for (int i = 0; i < 300; i++) begin
      step(($urandom % 60) == 0, ($urandom % 4) == 0, ($urandom % 8) == 0, 5'($urandom),
           ($urandom % 8) == 0, 5'($urandom), "rand");
    end

    step(0, 0, 0, 0, 1, 8, "j8");
    step(0, 0, 0, 0, 0, 0, "to9");
    check("pre_reset_addr", 32'(addr), 32'd9);
    check("pre_reset_valid", 32'(ifid_valid), 32'd1);
    step(1, 1, 0, 0, 1, 20, "mid_reset");
    check("mr_addr", 32'(addr), 32'd0);
    check("mr_instr", ifid_instr, 32'h0);
    check("mr_cnt", 32'(fcount), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
